// File: rtl/serial_bit_feeder.sv
// serial_bit_feeder: parallel-to-serial MSB-first feeder for the 101010 detector (optional PARITY_EN appends an even-parity bit)
module serial_bit_feeder #(
    parameter int   WIDTH      = 8,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       load_valid,
    output logic                       load_ready,
    input  logic [WIDTH-1:0]           load_data,
    input  logic [$clog2(WIDTH+1)-1:0] load_len,
    output logic                       x,
    output logic                       x_valid,
    output logic                       busy,
    output logic                       done
);
    localparam int LW = $clog2(WIDTH+1);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t           state, state_nx;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] aligned;
    logic [LW-1:0]    cnt;
    logic [LW-1:0]    eff_len;
    logic             x_q;
    logic             accept;
    logic             last;
    logic             tail_bit;
    assign eff_len = (load_len == '0 || load_len > LW'(WIDTH)) ? LW'(WIDTH) : load_len;
    assign aligned = load_data << (LW'(WIDTH) - eff_len);
    assign accept  = load_valid && load_ready;
`ifdef PARITY_EN
    logic par;
    logic par_phase;
    assign last     = state == SHIFT && cnt == '0 && par_phase;
    assign tail_bit = par;
    // parity accumulator and flag marking the extra parity cycle after the data bits
    always_ff @(posedge clock) begin
        if (reset) begin
            par       <= 1'b0;
            par_phase <= 1'b0;
        end else if (accept) begin
            par       <= ^aligned;
            par_phase <= 1'b0;
        end else if (state == SHIFT && cnt == '0) begin
            par_phase <= !par_phase;
        end
    end
`else
    assign last     = state == SHIFT && cnt == '0;
    assign tail_bit = IDLE_LEVEL;
`endif
    // state register
    always_ff @(posedge clock) begin
        state <= reset ? IDLE : state_nx;
    end
    // next-state: chaining a new word in the final cycle keeps us in SHIFT with no gap
    always_comb begin
        state_nx = state == IDLE ? (accept ? SHIFT : IDLE) : ((last && !accept) ? IDLE : SHIFT);
    end
    // outputs decoded from state; load_ready never looks at load_valid
    always_comb begin
        load_ready = state == IDLE || last;
        x_valid    = state == SHIFT;
        busy       = state == SHIFT;
        done       = last;
        x          = x_q;
    end
    // shift datapath: x is registered so the detector sees a full-period stable bit
    always_ff @(posedge clock) begin
        if (reset) begin
            x_q  <= IDLE_LEVEL;
            sreg <= '0;
            cnt  <= '0;
        end else if (accept) begin
            x_q  <= aligned[WIDTH-1];
            sreg <= aligned << 1;
            cnt  <= eff_len - 1'b1;
        end else if (last) begin
            x_q  <= IDLE_LEVEL;
            sreg <= '0;
            cnt  <= '0;
        end else if (state == SHIFT) begin
            x_q  <= cnt != '0 ? sreg[WIDTH-1] : tail_bit;
            sreg <= cnt != '0 ? sreg << 1 : sreg;
            cnt  <= cnt != '0 ? cnt - 1'b1 : cnt;
        end
    end
endmodule

// File: tb/tb_serial_bit_feeder.sv
// tb_serial_bit_feeder: scoreboard bench for serial_bit_feeder with directed words
module tb_serial_bit_feeder;
    localparam int   WIDTH = 8;
    localparam int   LW    = $clog2(WIDTH+1);
    localparam logic IDLE  = 1'b0;
    typedef struct packed {logic x; logic done;} exp_t;
    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             load_valid = 1'b0;
    logic [WIDTH-1:0] load_data = '0;
    logic [LW-1:0]    load_len = '0;
    logic             load_ready, x, x_valid, busy, done;
    exp_t             q[$];
    int               checks = 0;
    int               fails = 0;
    bit               mon_en = 1'b0;
    serial_bit_feeder #(.WIDTH(WIDTH), .IDLE_LEVEL(IDLE)) dut (
        .clock(clock), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .load_len(load_len), .x(x), .x_valid(x_valid), .busy(busy), .done(done)
    );
    always #5 clock = ~clock;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic push_word(input logic [31:0] bits, input int n);
        logic p;
        p = 1'b0;
        for (int i = n - 1; i >= 0; i--) begin
            p = p ^ bits[i];
`ifdef PARITY_EN
            q.push_back('{x: bits[i], done: 1'b0});
`else
            q.push_back('{x: bits[i], done: i == 0});
`endif
        end
`ifdef PARITY_EN
        q.push_back('{x: p, done: 1'b1});
`endif
    endtask
    task automatic send(input logic [WIDTH-1:0] data, input logic [LW-1:0] len, input bit hold,
                        input logic [31:0] bits, input int n);
        int t;
        t = 0;
        @(negedge clock);
        load_valid = 1'b1;
        load_data  = data;
        load_len   = len;
        while (!load_ready && t < 100) begin
            @(negedge clock);
            t++;
        end
        if (!load_ready) begin
            checks++;
            fails++;
            $display("FAIL accept_timeout: load_ready stayed 0 expected 1");
            load_valid = 1'b0;
            return;
        end
        @(posedge clock);
        push_word(bits, n);
        #1;
        if (!hold) load_valid = 1'b0;
    endtask
    task automatic drain();
        int t;
        t = 0;
        while (q.size() != 0 && t < 200) begin
            @(negedge clock);
            t++;
        end
        check("drain_left", q.size(), 0);
        repeat (3) @(negedge clock);
    endtask
    // monitor: every valid bit is popped and compared; idle cycles must show IDLE level and no done
    always @(negedge clock) begin
        if (mon_en) begin
            if (x_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL extra_bit: x_valid=1 with x=%0b expected no bit", x);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("x", x, e.x);
                    check("done", done, e.done);
                    check("busy", busy, 1);
                end
            end else begin
                check("idle_x", x, IDLE);
                check("idle_done", done, 0);
                check("idle_busy", busy, 0);
            end
        end
    end
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running expected finished");
        $fatal(1, "watchdog");
    end
    initial begin
        load_valid = 1'b1;
        load_data  = 8'hFF;
        repeat (3) begin
            @(posedge clock);
            #1;
            check("rst_x", x, IDLE);
            check("rst_x_valid", x_valid, 0);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_ready", load_ready, 1);
        end
        @(negedge clock);
        load_valid = 1'b0;
        reset      = 1'b0;
        mon_en     = 1'b1;
        repeat (3) @(negedge clock);
        send(8'b0010_1010, 6, 0, 6'b101010, 6);
        drain();
        send(8'b0000_0101, 3, 1, 3'b101, 3);
        send(8'b0000_0010, 3, 0, 3'b010, 3);
        drain();
        send(8'hA5, 0, 0, 8'hA5, 8);
        drain();
        send(8'h01, 1, 0, 1'b1, 1);
        drain();
        send(8'h3C, 12, 0, 8'h3C, 8);
        drain();
        send(8'hFD, 2, 0, 2'b01, 2);
        drain();
        send(8'h01, 1, 1, 1'b1, 1);
        send(8'h00, 1, 1, 1'b0, 1);
        send(8'h01, 1, 0, 1'b1, 1);
        drain();
        send(8'h09, 4, 0, 4'b1001, 4);
        load_valid = 1'b1;
        load_data  = 8'hFF;
        load_len   = 0;
        @(posedge clock);
        @(posedge clock);
        #1;
        load_valid = 1'b0;
        drain();
        send(8'h04, 3, 0, 3'b100, 3);
        drain();
        send(8'hFF, 8, 0, 8'hFF, 8);
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("abort_x", x, IDLE);
        check("abort_x_valid", x_valid, 0);
        check("abort_done", done, 0);
        check("abort_ready", load_ready, 1);
        q.delete();
        @(negedge clock);
        reset = 1'b0;
        repeat (12) @(negedge clock);
        send(8'b0000_0101, 3, 0, 3'b101, 3);
        drain();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/serial_bit_feeder.md
Name: serial_bit_feeder

Overview:
Parallel-to-serial stage placed directly upstream of the 101010 sequence detector. It accepts a word of up to WIDTH bits through a valid/ready handshake and drives it out MSB-first, one bit per clock, on the detector's serial input x. Back-to-back words stream with no idle cycle between them, so a detector pattern can span a word boundary.

Parameters:
WIDTH, 8, maximum word length in bits; legal range 2 to 32
IDLE_LEVEL, 1'b0, value driven on x while no word is being shifted

Ports:
clock  input  1  single system clock; all state changes on the rising edge
reset  input  1  synchronous, active-high reset
load_valid  input  1  upstream offers a word
load_ready  output  1  feeder can accept a word this cycle
load_data  input  WIDTH  word to send; bit [len-1] goes out first
load_len  input  $clog2(WIDTH+1)  number of bits to send; 0 means WIDTH
x  output  1  serial bit to the detector
x_valid  output  1  x carries a data (or parity) bit this cycle
busy  output  1  a word is in flight
done  output  1  one-cycle pulse in the cycle that drives the final bit of a word

Behaviour:
- Reset is synchronous and active-high; it dominates every other input.
- Values while reset is high and on the first edge after it: x=IDLE_LEVEL, x_valid=0, busy=0, done=0, load_ready=1, FSM=IDLE, shift register and bit counter cleared.
- Handshake: a word is accepted at a rising edge where load_valid && load_ready. load_data and load_len are sampled only at that edge.
- Effective length: L = WIDTH when load_len==0 or load_len>WIDTH; otherwise L = load_len.
- Latency: the first bit, load_data[L-1], appears on x in the cycle after acceptance, with x_valid=1 and busy=1.
- Each following cycle shifts out the next lower bit. load_data[0] is driven in cycle L after acceptance.
- FSM IDLE: load_ready=1, x_valid=0, x=IDLE_LEVEL. On accept, go to SHIFT.
- FSM SHIFT: the counter tracks the remaining bits. During the final bit cycle, done=1 and load_ready=1.
  - If a word is accepted in that cycle, stay in SHIFT. The new word's first bit follows the previous word's last bit with no gap.
  - Otherwise return to IDLE.
- load_ready is combinational from state only: (state==IDLE) || (final bit cycle). It never depends on load_valid.
- load_valid while load_ready=0: ignored; no buffering.
- Reset during SHIFT: the word is aborted. x returns to IDLE_LEVEL on the next edge, no done pulse, and no residual bits are emitted afterwards.
- L=1 is legal: a single bit cycle with done=1 in that same cycle.
- x is a registered output, so the detector sees a glitch-free bit stable for a full clock period.

Optional Feature:
Macro PARITY_EN.
- Defined: after the L data bits, one extra SHIFT cycle drives the even-parity bit (XOR of the L transmitted bits) with x_valid=1. done and load_ready move to this parity cycle; back-to-back chaining still has no gap.
- Not defined: no parity cycle; behaviour exactly as described above.

Test Plan:
- Reset: hold reset high 3 cycles while driving load_valid=1 -> x=0, x_valid=0, busy=0, done=0, load_ready=1 throughout; no word accepted.
- Single word: WIDTH=8, load_data=8'b0010_1010, load_len=6, one-cycle valid -> x = 1,0,1,0,1,0 in cycles 1-6 after accept; x_valid=1 for those 6 cycles; done=1 only in cycle 6; the detector's z pulses on the final bit.
- Back-to-back: word A=3'b101 (len 3), then B=3'b010 (len 3) with load_valid held -> B is accepted in A's final bit cycle; x = 1,0,1,0,1,0 contiguous; x_valid never drops; done pulses in cycles 3 and 6.
- Length rules: load_len=0 with load_data=8'hA5 -> 8 bits 1,0,1,0,0,1,0,1. load_len=1 with data bit0=1 -> one bit, done in the same cycle.
- Abort: accept 8'hFF with len 8, assert reset in bit cycle 4 -> x=0 and x_valid=0 from the next edge; no done; load_ready=1.
- PARITY_EN build: send 3'b101 -> x = 1,0,1 then parity bit 0; done only in the 4th cycle. Send 3'b100 -> parity bit 1.
